// File: rtl/match_frame_counter.sv
// Counts equal compare results over a frame of LEN samples and reports the count and pass flag.
// Optional FIRST_MISS_EN macro adds the first_miss output (index of first unequal sample).
module match_frame_counter #(
   parameter int LEN = 16,
   parameter int W   = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         in_valid,
   input  logic         aeqb,
   output logic         in_ready,
   output logic         busy,
   output logic         done_tick,
   output logic [W-1:0] match_cnt,
`ifdef FIRST_MISS_EN
   output logic         pass,
   output logic [W-1:0] first_miss
`else
   output logic         pass
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [W-1:0] LEN_W    = W'(LEN);
   localparam logic [W-1:0] LAST_IDX = W'(LEN - 1);

   logic [1:0]   state;
   logic [W-1:0] idx;
   logic [W-1:0] work_cnt;
   logic [W-1:0] next_cnt;
   logic         accept;
   logic         last;

   always_comb begin
      accept   = (state == RUN) && in_valid;
      next_cnt = work_cnt + {{(W-1){1'b0}}, aeqb};
      last     = (idx == LAST_IDX);
   end

   assign in_ready  = (state == RUN);
   assign busy      = (state != IDLE);
   assign done_tick = (state == DONE);

   // Frame results are published on the same edge that enters DONE and held until the next one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         work_cnt  <= '0;
         match_cnt <= '0;
         pass      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  idx      <= '0;
                  work_cnt <= '0;
               end
            end
            RUN: begin
               if (accept) begin
                  work_cnt <= next_cnt;
                  idx      <= idx + W'(1);
                  if (last) begin
                     state     <= DONE;
                     match_cnt <= next_cnt;
                     pass      <= (next_cnt == LEN_W);
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FIRST_MISS_EN
   logic [W-1:0] work_miss;
   logic         miss_now;

   // LEN doubles as the "no miss yet" marker, since no real index reaches it.
   always_comb begin
      miss_now = accept && !aeqb && (work_miss == LEN_W);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         work_miss  <= '0;
         first_miss <= '0;
      end else begin
         if (state == IDLE && start) begin
            work_miss <= LEN_W;
         end else if (accept) begin
            if (miss_now) begin
               work_miss <= idx;
            end
            if (last) begin
               first_miss <= miss_now ? idx : work_miss;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_match_frame_counter.sv
// Directed bench for match_frame_counter: a LEN=16 instance for the frame scenarios and a LEN=1
// instance for the single-sample frame; first_miss is checked when FIRST_MISS_EN is defined.
module tb_match_frame_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, in_valid, aeqb;
   logic       in_ready, busy, done_tick, pass;
   logic [4:0] match_cnt;
   logic       start1, in_valid1, aeqb1;
   logic       in_ready1, busy1, done_tick1, pass1;
   logic [4:0] match_cnt1;
`ifdef FIRST_MISS_EN
   logic [4:0] first_miss, first_miss1;
`endif

   int vecCount  = 0;
   int errCount  = 0;
   int doneCount = 0;

   always #5 clk = ~clk;

   match_frame_counter #(.LEN(16), .W(5)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .aeqb(aeqb),
      .in_ready(in_ready), .busy(busy), .done_tick(done_tick), .match_cnt(match_cnt),
`ifdef FIRST_MISS_EN
      .pass(pass), .first_miss(first_miss)
`else
      .pass(pass)
`endif
   );

   match_frame_counter #(.LEN(1), .W(5)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid1), .aeqb(aeqb1),
      .in_ready(in_ready1), .busy(busy1), .done_tick(done_tick1), .match_cnt(match_cnt1),
`ifdef FIRST_MISS_EN
      .pass(pass1), .first_miss(first_miss1)
`else
      .pass(pass1)
`endif
   );

   always @(negedge clk) begin
      if (done_tick) doneCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      if (obs !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one LEN=16 frame; the start cycle also presents a valid sample that must be ignored.
   task automatic applyStimulus(input string tag, input logic [15:0] eq, input bit gaps,
                                input bit pokeStart, input logic [4:0] prevMatch,
                                output int cyc);
      int k;
      bit v;
      start = 1'b1; in_valid = 1'b1; aeqb = 1'b0;
      tick();
      start = 1'b0;
      checkOutput({tag, "_run_ready"}, {31'd0, in_ready}, 32'd1);
      cyc = 0;
      k = 0;
      while (!done_tick && cyc < 100) begin
         v = gaps ? cyc[0] : 1'b1;
         in_valid = v;
         aeqb = (k < 16) ? eq[k] : 1'b1;
         start = pokeStart;
         if (cyc == 5) checkOutput({tag, "_hold_cnt"}, {27'd0, match_cnt}, {27'd0, prevMatch});
         tick();
         if (v) k++;
         cyc++;
      end
      start = 1'b0;
      in_valid = 1'b0;
      if (cyc >= 100) checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
      checkOutput({tag, "_done_busy"}, {31'd0, busy}, 32'd1);
      checkOutput({tag, "_done_ready"}, {31'd0, in_ready}, 32'd0);
      start = pokeStart;
      tick();
      start = 1'b0;
      checkOutput({tag, "_done_once"}, {31'd0, done_tick}, 32'd0);
      tick();
      checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   int cyc, dc;

   initial begin
      reset = 1'b1;
      start = 1'b0; in_valid = 1'b0; aeqb = 1'b0;
      start1 = 1'b0; in_valid1 = 1'b0; aeqb1 = 1'b0;
      tick();
      tick();
      checkOutput("rst_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done_tick}, 32'd0);
      checkOutput("rst_cnt", {27'd0, match_cnt}, 32'd0);
      checkOutput("rst_pass", {31'd0, pass}, 32'd0);
`ifdef FIRST_MISS_EN
      checkOutput("rst_fm", {27'd0, first_miss}, 32'd0);
`endif
      reset = 1'b0;
      in_valid = 1'b1;
      tick();
      tick();
      checkOutput("post_rst_idle", {31'd0, busy}, 32'd0);
      in_valid = 1'b0;

      // All samples equal
      dc = doneCount;
      applyStimulus("f1", 16'hFFFF, 1'b0, 1'b0, 5'd0, cyc);
      checkOutput("f1_latency", cyc, 32'd16);
      checkOutput("f1_cnt", {27'd0, match_cnt}, 32'd16);
      checkOutput("f1_pass", {31'd0, pass}, 32'd1);
      checkOutput("f1_ndone", doneCount - dc, 32'd1);
`ifdef FIRST_MISS_EN
      checkOutput("f1_fm", {27'd0, first_miss}, 32'd16);
`endif

      // Misses at indices 3 and 9
      applyStimulus("f2", 16'hFDF7, 1'b0, 1'b0, 5'd16, cyc);
      checkOutput("f2_cnt", {27'd0, match_cnt}, 32'd14);
      checkOutput("f2_pass", {31'd0, pass}, 32'd0);
`ifdef FIRST_MISS_EN
      checkOutput("f2_fm", {27'd0, first_miss}, 32'd3);
`endif

      // in_valid alternates 0/1 starting low on RUN entry
      applyStimulus("f3", 16'h0F0F, 1'b1, 1'b0, 5'd14, cyc);
      checkOutput("f3_latency", cyc, 32'd32);
      checkOutput("f3_cnt", {27'd0, match_cnt}, 32'd8);
      checkOutput("f3_pass", {31'd0, pass}, 32'd0);
`ifdef FIRST_MISS_EN
      checkOutput("f3_fm", {27'd0, first_miss}, 32'd4);
`endif

      // start held high through RUN and DONE
      dc = doneCount;
      applyStimulus("f4", 16'h8001, 1'b0, 1'b1, 5'd8, cyc);
      checkOutput("f4_ndone", doneCount - dc, 32'd1);
      checkOutput("f4_cnt", {27'd0, match_cnt}, 32'd2);
`ifdef FIRST_MISS_EN
      checkOutput("f4_fm", {27'd0, first_miss}, 32'd1);
`endif

      // Reset after 7 accepted samples
      dc = doneCount;
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1; aeqb = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("mid_rst_cnt", {27'd0, match_cnt}, 32'd0);
      checkOutput("mid_rst_pass", {31'd0, pass}, 32'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      in_valid = 1'b0;
      checkOutput("mid_rst_idle", {31'd0, busy}, 32'd0);
      checkOutput("mid_rst_nodone", doneCount - dc, 32'd0);
      applyStimulus("f5", 16'hFFFF, 1'b0, 1'b0, 5'd0, cyc);
      checkOutput("f5_cnt", {27'd0, match_cnt}, 32'd16);
      checkOutput("f5_pass", {31'd0, pass}, 32'd1);

      // Single-sample frames
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      in_valid1 = 1'b1; aeqb1 = 1'b0;
      tick();
      in_valid1 = 1'b0;
      checkOutput("len1_done", {31'd0, done_tick1}, 32'd1);
      checkOutput("len1_cnt0", {27'd0, match_cnt1}, 32'd0);
      checkOutput("len1_pass0", {31'd0, pass1}, 32'd0);
`ifdef FIRST_MISS_EN
      checkOutput("len1_fm0", {27'd0, first_miss1}, 32'd0);
`endif
      tick();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      in_valid1 = 1'b1; aeqb1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      checkOutput("len1_done1", {31'd0, done_tick1}, 32'd1);
      checkOutput("len1_cnt1", {27'd0, match_cnt1}, 32'd1);
      checkOutput("len1_pass1", {31'd0, pass1}, 32'd1);
`ifdef FIRST_MISS_EN
      checkOutput("len1_fm1", {27'd0, first_miss1}, 32'd1);
`endif
      tick();
      checkOutput("len1_idle", {31'd0, busy1}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
